// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: pipe register indices,
// forwarding selects and controller states.
package pipe_hazard_ctrl_pkg;

    localparam int NUM_STAGES = 5;

    typedef enum logic [2:0] {
        PC     = 3'd0,
        IF_ID  = 3'd1,
        ID_EX  = 3'd2,
        EX_MEM = 3'd3,
        MEM_WB = 3'd4
    } pipe_stage_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(parameter int REG_ADDR_W = 5) ();
    import pipe_hazard_ctrl_pkg::*;

    // Cache handshakes are request/response: a request stays high until the cycle
    // its response is seen; request & ~response marks a stalled access that cycle.
    logic                  imem_read;
    logic                  imem_resp;
    logic                  dmem_req;
    logic                  dmem_resp;
    logic                  redirect;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  ex_ld_reg;
    logic                  mem_ld_reg;
    logic                  wb_ld_reg;
    logic                  ex_is_load;

    logic [NUM_STAGES-1:0] stage_load;
    logic [NUM_STAGES-1:0] stage_flush;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [1:0]            fwd_sel1;
    logic [1:0]            fwd_sel2;
    ctrl_state_t           dbg_state;

    modport master (
        output imem_read, imem_resp, dmem_req, dmem_resp, redirect,
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2,
        output ex_rd, mem_rd, wb_rd, ex_ld_reg, mem_ld_reg, wb_ld_reg, ex_is_load,
        input  stage_load, stage_flush, stage_valid, fwd_sel1, fwd_sel2, dbg_state
    );

    modport slave (
        input  imem_read, imem_resp, dmem_req, dmem_resp, redirect,
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2,
        input  ex_rd, mem_rd, wb_rd, ex_ld_reg, mem_ld_reg, wb_ld_reg, ex_is_load,
        output stage_load, stage_flush, stage_valid, fwd_sel1, fwd_sel2, dbg_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_fwd_unit.sv
// Combinational RAW hazard detection against EX/MEM and forwarding select for EX operands.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  ex_ld_reg,
    input  logic                  mem_ld_reg,
    input  logic                  wb_ld_reg,
    input  logic                  ex_is_load,
    input  logic                  mem_valid,
    input  logic                  wb_valid,
    output logic                  hazard,
    output fwd_sel_t              fwd_sel1,
    output fwd_sel_t              fwd_sel2
);

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic dep_hit(input logic en, input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rd, input logic wr);
        return en && wr && (rs != '0) && (rs == rd);
    endfunction

    function automatic fwd_sel_t pick_src(input logic [REG_ADDR_W-1:0] rs);
        if (!FWD_EN)                                 return FWD_RF;
        if (dep_hit(mem_valid, rs, mem_rd, mem_ld_reg)) return FWD_MEM;
        if (dep_hit(wb_valid, rs, wb_rd, wb_ld_reg))    return FWD_WB;
        return FWD_RF;
    endfunction

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit  = dep_hit(id_use_rs1, id_rs1, ex_rd, ex_ld_reg)
                | dep_hit(id_use_rs2, id_rs2, ex_rd, ex_ld_reg);
        mem_hit = dep_hit(id_use_rs1, id_rs1, mem_rd, mem_ld_reg)
                | dep_hit(id_use_rs2, id_rs2, mem_rd, mem_ld_reg);
        if (FWD_EN) hazard = ex_hit & ex_is_load;
        else        hazard = ex_hit | mem_hit;
        fwd_sel1 = pick_src(ex_rs1);
        fwd_sel2 = pick_src(ex_rs2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline controller: pipe register load/bubble enables, valid tracking,
// dropped-fetch handling after redirects, and saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int BR_STAGE   = 2,
    parameter bit FWD_EN     = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_state_t           state_q, state_d;
    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [NUM_STAGES-1:0] load, flush, prev_valid;
    logic                  mem_stall, if_stall, hazard;
    fwd_sel_t              fwd1, fwd2;

    hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_hazard_fwd (
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_use_rs1 (bus.id_use_rs1),
        .id_use_rs2 (bus.id_use_rs2),
        .ex_rs1     (bus.ex_rs1),
        .ex_rs2     (bus.ex_rs2),
        .ex_rd      (bus.ex_rd),
        .mem_rd     (bus.mem_rd),
        .wb_rd      (bus.wb_rd),
        .ex_ld_reg  (bus.ex_ld_reg),
        .mem_ld_reg (bus.mem_ld_reg),
        .wb_ld_reg  (bus.wb_ld_reg),
        .ex_is_load (bus.ex_is_load),
        .mem_valid  (valid_q[EX_MEM]),
        .wb_valid   (valid_q[MEM_WB]),
        .hazard     (hazard),
        .fwd_sel1   (fwd1),
        .fwd_sel2   (fwd2)
    );

    always_comb begin
        mem_stall = bus.dmem_req & ~bus.dmem_resp;
        if_stall  = bus.imem_read & ~bus.imem_resp;
        load      = '1;
        flush     = '0;
        state_d   = state_q;
        if (reset) begin
            load  = '0;
            flush = '1;
        end else if (mem_stall) begin
            load = '0;
        end else if (bus.redirect) begin
            flush[IF_ID] = 1'b1;
            if (BR_STAGE == 2) flush[ID_EX] = 1'b1;
            // A fetch still in flight belongs to the wrong path and must be discarded.
            if (if_stall || state_q == DROP) state_d = DROP;
        end else begin
            if (hazard) begin
                load[PC]      = 1'b0;
                load[IF_ID]   = 1'b0;
                flush[ID_EX]  = 1'b1;
            end else if (if_stall || state_q == DROP) begin
                load[PC]      = 1'b0;
                flush[IF_ID]  = 1'b1;
            end
            if (state_q == DROP && bus.imem_resp) state_d = RUN;
        end
    end

    always_comb begin
        prev_valid = {valid_q[NUM_STAGES-2:0], 1'b1};
        for (int i = 0; i < NUM_STAGES; i++) begin
            valid_d[i] = valid_q[i];
            if (load[i]) valid_d[i] = flush[i] ? 1'b0 : prev_valid[i];
        end
        stall_cnt_d = stall_cnt_q;
        if (!reset && !(&load) && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
        flush_cnt_d = flush_cnt_q;
        if (!reset && !mem_stall && bus.redirect && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            valid_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        bus.stage_load  = load;
        bus.stage_flush = flush;
        bus.stage_valid = valid_q;
        bus.fwd_sel1    = reset ? FWD_RF : fwd1;
        bus.fwd_sel2    = reset ? FWD_RF : fwd2;
        bus.dbg_state   = state_q;
        stall_cnt       = stall_cnt_q;
        flush_cnt       = flush_cnt_q;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised next-generation pipeline controller for the 5-stage RV32I core.
- Sits between the I/D cache handshakes, the control words of ID/EX/MEM/WB and the pipe registers.
- Generates per-register load and bubble-insert enables, tracks per-stage valid bits and resolves load-use and RAW hazards, with or without forwarding.
- Discards fetches that were in flight when a redirect occurred, and keeps saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register-index width
BR_STAGE, 2, stage resolving redirects (1=ID, 2=EX); sets how many younger registers are flushed
FWD_EN, 1, 1=forwarding from MEM/WB with load-use stall only; 0=stall on any RAW hazard against EX/MEM
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
imem_read  in  1  IF fetch request outstanding
imem_resp  in  1  I-cache response
dmem_req  in  1  valid load/store in MEM stage
dmem_resp  in  1  D-cache response
redirect  in  1  taken branch/jump at BR_STAGE
id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  REG_ADDR_W  EX source registers (forwarding)
ex_rd, mem_rd, wb_rd  in  REG_ADDR_W  destination registers
ex_ld_reg, mem_ld_reg, wb_ld_reg  in  1  stage writes regfile
ex_is_load  in  1  EX instruction is a load
stage_load  out  5  load enable: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
stage_flush  out  5  bubble insert per register (valid only with stage_load)
stage_valid  out  5  valid bit of each register
fwd_sel1, fwd_sel2  out  2  00 regfile, 01 MEM, 10 WB
stall_cnt  out  CNT_W  cycles with any register held
flush_cnt  out  CNT_W  accepted redirects

Behaviour:
- Reset (sync): stage_load=0, stage_flush=5'b11111, stage_valid=0, fwd_sel=0, counters=0, state=RUN.
- Events: mem_stall=dmem_req&~dmem_resp; if_stall=imem_read&~imem_resp.
- hazard: match of id_rs* (used, nonzero) with ex_rd.
  - FWD_EN=1: hazard requires ex_ld_reg&ex_is_load.
  - FWD_EN=0: hazard is any match with ex_rd (ex_ld_reg) or mem_rd (mem_ld_reg).
- Priority, highest first: reset > mem_stall > redirect > hazard > if_stall > normal.
- mem_stall: stage_load=0 (whole pipe frozen); redirect/hazard re-evaluated on release.
- redirect: stage_load=all 1.
  - BR_STAGE=1: stage_flush[1]=1.
  - BR_STAGE=2: stage_flush[2:1]=2'b11.
  - flush_cnt+1.
  - If if_stall same cycle: state->DROP.
- hazard: load[1:0]=0; bubble into ID/EX (load[2]=1, flush[2]=1); load[4:3]=1.
- if_stall (RUN): load[0]=0; IF/ID bubble (load[1]=1, flush[1]=1); downstream advance.
- States: RUN, DROP.
  - DROP: wait for imem_resp. The response cycle bubbles IF/ID (flush[1]=1) and holds PC (load[0]=0), then ->RUN.
  - A further redirect in DROP stays in DROP.
  - mem_stall in DROP freezes as usual.
- Combinational outputs: stage_load/stage_flush depend on current inputs and state, same cycle, no latency.
- stage_valid updates on the clock edge per register:
  - load&flush -> 0
  - load&~flush -> valid of previous stage (PC stage valid=1 after reset)
  - ~load -> hold
- Forwarding (FWD_EN=1): fwd_sel=01 if mem_ld_reg&mem_rd==ex_rsX&mem_rd!=0 and MEM valid; else 10 on the same rule for WB; else 00. MEM beats WB. FWD_EN=0: fwd_sel constantly 00.
- x0 is never a hazard or forward source.
- Counters: stall_cnt+1 whenever any stage_load bit is 0 outside reset. Both counters saturate at all ones, no wrap.

Decomposition:
- rv32i_types gains: pipe_stage_t enum (PC, IF_ID, ID_EX, EX_MEM, MEM_WB), fwd_sel_t enum, ctrl_state_t enum (RUN, DROP).
- One sub-module: hazard_fwd_unit (combinational hazard detect + forwarding select, parametrised by REG_ADDR_W, FWD_EN). FSM, valid tracking and counters stay in pipe_hazard_ctrl.

Test Plan:
- Reset mid-stall: dmem_req=1, dmem_resp=0 for 3 cycles, reset pulse -> stage_load=0, flush=11111, valid=0, counters 0, state RUN next cycle.
- Load-use, FWD_EN=1: ex_is_load, ex_rd=5, id_rs1=5 -> load=5'b11100, flush[2]=1 for one cycle, stall_cnt+1; ex_rd=0 -> no stall.
- Forward priority: mem_rd=wb_rd=ex_rs2=7, both writing -> fwd_sel2=01; mem_ld_reg=0 -> 10; FWD_EN=0 build, mem_rd=id_rs1=7 -> stall.
- Redirect during I-miss, BR_STAGE=2: redirect with imem_read=1, imem_resp=0 -> flush[2:1]=11, flush_cnt=1, DROP; resp 4 cycles later -> flush[1]=1, load[0]=0, back to RUN.
- Redirect under D-miss: redirect and mem_stall together for 2 cycles -> load=0, flush_cnt unchanged; on dmem_resp, redirect accepted once, flush_cnt=1.
- Counter saturation (CNT_W=4): 20 stall cycles -> stall_cnt=15 and holds.
